// File: rtl/bsg_wormhole_responder_pkg.sv
// Shared types and header layout helpers for wormhole echo endpoints.
// The header struct macro builds a packed header for any width set.

`define BSG_WORMHOLE_RESPONDER_HEADER_S(flit_w, cord_w, len_w, name) \
   typedef struct packed { \
      logic [(flit_w)-2*(cord_w)-(len_w)-1:0] user; \
      logic [(cord_w)-1:0] src; \
      logic [(len_w)-1:0] len; \
      logic [(cord_w)-1:0] dest; \
   } name

package bsg_wormhole_responder_pkg;

   typedef enum logic [0:0] {
      eHeader  = 1'b0,
      ePayload = 1'b1
   } bsg_wormhole_responder_state_e;

   function automatic int hdr_dest_lsb();
      return 0;
   endfunction

   function automatic int hdr_len_lsb(input int cord_w);
      return cord_w;
   endfunction

   function automatic int hdr_src_lsb(input int cord_w,
                                      input int len_w);
      return cord_w + len_w;
   endfunction

   function automatic int hdr_user_lsb(input int cord_w,
                                       input int len_w);
      return 2 * cord_w + len_w;
   endfunction

   function automatic int hdr_user_width(input int flit_w,
                                         input int cord_w,
                                         input int len_w);
      return flit_w - hdr_user_lsb(cord_w, len_w);
   endfunction

endpackage

// File: rtl/bsg_wormhole_loopback_responder_if.sv
// Ready-and link channel: producer drives v/data, consumer drives ready.
// One instance per direction of flow.

interface bsg_wormhole_loopback_responder_if #(
   parameter int width_p = 32
) ();

   logic               v;
   logic [width_p-1:0] data;
   logic               ready_and;

   modport master (
      output v,
      output data,
      input  ready_and
   );

   modport slave (
      input  v,
      input  data,
      output ready_and
   );

endinterface

// File: rtl/bsg_two_fifo.sv
// Two-entry ready/valid buffer; ready is a pure function of occupancy.
// Valid and data come from registers so nothing is combinational across it.

module bsg_two_fifo #(
   parameter int width_p = 32
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic [width_p-1:0] data_i,
   input  logic               v_i,
   output logic               ready_o,
   output logic               v_o,
   output logic [width_p-1:0] data_o,
   input  logic               yumi_i
);

   logic [width_p-1:0] mem_r [2];
   logic               head_r;
   logic               tail_r;
   logic [1:0]         count_r;
   logic               enq;
   logic               deq;

   assign ready_o = (count_r != 2'd2);
   assign v_o     = (count_r != 2'd0);
   assign data_o  = mem_r[head_r];
   assign enq     = v_i & ready_o;
   assign deq     = yumi_i & v_o;

   // Pointer and occupancy tracking; reset empties the buffer.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         head_r  <= 1'b0;
         tail_r  <= 1'b0;
         count_r <= 2'd0;
      end else begin
         if (enq) tail_r <= ~tail_r;
         if (deq) head_r <= ~head_r;
         count_r <= count_r + {1'b0, enq} - {1'b0, deq};
      end
   end

   // Storage write; contents need no reset since occupancy gates them.
   always_ff @(posedge clk_i) begin
      if (enq) mem_r[tail_r] <= data_i;
   end

endmodule

// File: rtl/bsg_wormhole_header_swap.sv
// Combinational header rewrite for echo endpoints: reply goes back to src.
// Also flags a request whose dest does not name this endpoint.

module bsg_wormhole_header_swap
   import bsg_wormhole_responder_pkg::*;
#(
   parameter int flit_width_p = 32,
   parameter int cord_width_p = 8,
   parameter int len_width_p  = 4
) (
   input  logic [flit_width_p-1:0] hdr_i,
   input  logic [cord_width_p-1:0] my_cord_i,
   output logic [flit_width_p-1:0] hdr_o,
   output logic [len_width_p-1:0]  len_o,
   output logic                    dest_mismatch_o
);

   `BSG_WORMHOLE_RESPONDER_HEADER_S(flit_width_p, cord_width_p,
                                    len_width_p, hdr_s);

   hdr_s hdr_in;
   hdr_s hdr_out;

   // Swap routing fields; len and user bits ride through untouched.
   always_comb begin
      hdr_in       = hdr_i;
      hdr_out      = hdr_in;
      hdr_out.dest = hdr_in.src;
      hdr_out.src  = my_cord_i;
   end

   assign hdr_o           = hdr_out;
   assign len_o           = hdr_in.len;
   assign dest_mismatch_o = (hdr_in.dest != my_cord_i);

endmodule

// File: rtl/bsg_wormhole_loopback_responder.sv
// Wormhole loopback endpoint: answers every request packet with one reply.
// Reply header is routed back to the sender; payload is echoed (XORed).

module bsg_wormhole_loopback_responder
   import bsg_wormhole_responder_pkg::*;
#(
   parameter int                     flit_width_p  = 32,
   parameter int                     cord_width_p  = 8,
   parameter int                     len_width_p   = 4,
   parameter logic [flit_width_p-1:0] payload_xor_p = '0
) (
   input  logic                    clk_i,
   input  logic                    reset_n_i,
   input  logic [cord_width_p-1:0] my_cord_i,
   bsg_wormhole_loopback_responder_if.slave  link_i,
   bsg_wormhole_loopback_responder_if.master link_o,
   output logic [31:0]             packets_o,
   output logic                    error_o
);

   if (hdr_user_lsb(cord_width_p, len_width_p) > flit_width_p)
   begin : g_width_chk
      $error("header fields do not fit in flit_width_p");
   end

   localparam logic [0:0] st_header  = eHeader;
   localparam logic [0:0] st_payload = ePayload;

   logic                    in_v;
   logic                    in_ready;
   logic [flit_width_p-1:0] in_data;

   logic                    out_ready;
   logic                    out_v;
   logic [flit_width_p-1:0] out_data;
   logic [flit_width_p-1:0] enq_data;
   logic                    out_yumi;

   logic [flit_width_p-1:0] swap_hdr;
   logic [len_width_p-1:0]  hdr_len;
   logic                    dest_mismatch;

   logic [0:0]              state_r;
   logic [len_width_p-1:0]  remaining_r;
   logic [31:0]             packets_r;
   logic                    error_r;

   logic                    fire;
   logic                    is_header;
   logic                    pkt_done;

   bsg_two_fifo #(
      .width_p (flit_width_p)
   ) in_fifo (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .data_i    (link_i.data),
      .v_i       (link_i.v),
      .ready_o   (in_ready),
      .v_o       (in_v),
      .data_o    (in_data),
      .yumi_i    (fire)
   );

   bsg_wormhole_header_swap #(
      .flit_width_p (flit_width_p),
      .cord_width_p (cord_width_p),
      .len_width_p  (len_width_p)
   ) swap (
      .hdr_i           (in_data),
      .my_cord_i       (my_cord_i),
      .hdr_o           (swap_hdr),
      .len_o           (hdr_len),
      .dest_mismatch_o (dest_mismatch)
   );

   bsg_two_fifo #(
      .width_p (flit_width_p)
   ) out_fifo (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .data_i    (enq_data),
      .v_i       (fire),
      .ready_o   (out_ready),
      .v_o       (out_v),
      .data_o    (out_data),
      .yumi_i    (out_yumi)
   );

   // Both links are held quiet while reset is applied.
   assign link_i.ready_and = in_ready & reset_n_i;
   assign link_o.v         = out_v & reset_n_i;
   assign link_o.data      = out_data;
   assign out_yumi         = out_v & reset_n_i & link_o.ready_and;

   assign is_header = (state_r == st_header);
   assign fire      = in_v & out_ready;

   assign pkt_done = fire & (is_header
                     ? (hdr_len == '0)
                     : (remaining_r == len_width_p'(1)));

   // Select the reply flit: rewritten header or transformed payload.
   always_comb begin
      enq_data = in_data ^ payload_xor_p;
      unique case (1'b1)
         is_header:  enq_data = swap_hdr;
         !is_header: enq_data = in_data ^ payload_xor_p;
      endcase
   end

   // Packet framing: track header vs payload and flits left to echo.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_r     <= st_header;
         remaining_r <= '0;
      end else if (fire) begin
         unique case (1'b1)
            is_header: begin
               remaining_r <= hdr_len;
               if (hdr_len != '0) state_r <= st_payload;
            end
            !is_header: begin
               remaining_r <= remaining_r - len_width_p'(1);
               if (remaining_r == len_width_p'(1))
                  state_r <= st_header;
            end
         endcase
      end
   end

   // Completed-packet count and sticky misroute flag.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         packets_r <= '0;
         error_r   <= 1'b0;
      end else begin
         if (pkt_done) packets_r <= packets_r + 32'd1;
         if (fire && is_header && dest_mismatch) error_r <= 1'b1;
      end
   end

   assign packets_o = packets_r;
   assign error_o   = error_r;

endmodule
